// File: rtl/multicycle_cpu_pkg.sv
// multicycle_cpu_pkg: shared types and encoding constants for the multicycle CPU
package multicycle_cpu_pkg;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT} alu_op_t;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  // funct3 to ALU operation, shared by R-type and I-type decode
  function automatic alu_op_t f3_op(input logic [2:0] f3);
    return f3 == F3_SLL ? ALU_SLL : f3 == F3_SLT ? ALU_SLT : f3 == F3_XOR ? ALU_XOR :
           f3 == F3_SR ? ALU_SRL : f3 == F3_OR ? ALU_OR : f3 == F3_AND ? ALU_AND : ALU_ADD;
  endfunction
endpackage

// File: rtl/multicycle_cpu_alu.sv
// multicycle_cpu_alu: combinational 32-bit ALU
module multicycle_cpu_alu
  import multicycle_cpu_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  // operation select; shifts use only the low five bits of b
  always_comb begin
    y = a + b;
    case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << b[4:0];
      ALU_SRL: y = a >> b[4:0];
      ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
      default: y = a + b;
    endcase
  end
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: four-state RV32 subset CPU with ROM, register file and sticky halt
module multicycle_cpu
  import multicycle_cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = 32,
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] initial_instructions [IMEM_DEPTH],
  input  logic [31:0] initial_register_values [NREGS],
  output logic [31:0] register_check [NREGS],
  output logic [31:0] pc_out_check,
  output logic [2:0]  state_check,
  output logic [31:0] retired_count,
  output logic        halted
);
  localparam int AW = $clog2(NREGS);
  localparam int IW = IMEM_DEPTH > 1 ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [5:0] NR = 6'(NREGS);
  state_t state;
  logic [31:0] pc, ir, a_q, b_q, imm_q, res_q, alu_y, imm;
  logic [31:0] regs [NREGS];
  logic [4:0] rd_q;
  alu_op_t op_q, dec_op;
  logic br_q, bne_q, dec_ok, idx_ok, is_i, is_b, taken;
  wire [6:0] opc = ir[6:0];
  wire [2:0] f3 = ir[14:12];
  wire [6:0] f7 = ir[31:25];
  wire [4:0] rd = ir[11:7];
  wire [4:0] rs1 = ir[19:15];
  wire [4:0] rs2 = ir[24:20];
  assign is_i = opc == OP_I;
  assign is_b = opc == OP_B;
  assign imm = is_b ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} : {{20{ir[31]}}, ir[31:20]};
  assign idx_ok = {1'b0, rs1} < NR && (is_i || {1'b0, rs2} < NR) && (is_b || {1'b0, rd} < NR);
  assign taken = bne_q ? alu_y != '0 : alu_y == '0;
  assign register_check = regs;
  assign pc_out_check = pc;
  assign state_check = state;
  assign halted = state == HALT;
  // instruction decode: legality and ALU operation for the latched instruction
  always_comb begin
    dec_ok = 1'b0;
    dec_op = f3_op(f3);
    if (opc == OP_R && f7 == F7_SUB) begin
      dec_ok = f3 == F3_ADD;
      dec_op = ALU_SUB;
    end else if (opc == OP_R && f7 == F7_BASE) begin
      dec_ok = f3 != 3'b011;
    end else if (is_i) begin
      dec_ok = f3 inside {F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND};
    end else if (is_b) begin
      dec_ok = f3 inside {F3_BEQ, F3_BNE};
      dec_op = ALU_SUB;
    end
  end
  multicycle_cpu_alu u_alu (.op(op_q), .a(a_q), .b(b_q), .y(alu_y));
  // control FSM, register file and architectural state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= '0;
      retired_count <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= i == 0 ? '0 : initial_register_values[i];
    end else begin
      case (state)
        FETCH: begin
          if (pc[1:0] != 2'b00 || (pc >> 2) >= 32'(IMEM_DEPTH)) state <= HALT;
          else begin
            ir <= initial_instructions[pc[IW+1:2]];
            state <= DECODE;
          end
        end
        DECODE: begin
          if (dec_ok && idx_ok) begin
            a_q <= regs[rs1[AW-1:0]];
            b_q <= is_i ? imm : regs[rs2[AW-1:0]];
            imm_q <= imm;
            op_q <= dec_op;
            rd_q <= rd;
            br_q <= is_b;
            bne_q <= f3 == F3_BNE;
            state <= EXECUTE;
          end else state <= HALT;
        end
        EXECUTE: begin
          res_q <= alu_y;
          if (br_q) begin
            pc <= taken ? pc + imm_q : pc + 32'd4;
            retired_count <= retired_count + 32'd1;
            state <= FETCH;
          end else state <= WRITEBACK;
        end
        WRITEBACK: begin
          if (rd_q != '0) regs[rd_q[AW-1:0]] <= res_q;
          pc <= pc + 32'd4;
          retired_count <= retired_count + 32'd1;
          state <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule
